// File: rtl/iob_indir_pkg.sv
// Shared types and default sizing for the IOB indirect-store controller.
package iob_indir_pkg;

  localparam int IOB_ADDR_WIDTH = 6;
  localparam int IOB_COUNT      = 64;
  localparam int IOB_DATA_WIDTH = 65;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } iob_state_e;

  // Identifies which of the two read requesters a grant/response belongs to
  typedef logic [0:0] iob_req_id_t;

endpackage

// File: rtl/iob_indir_ffs.sv
// Lowest-set-bit finder; used to pick the lowest-index free entry.
module iob_indir_ffs
  import iob_indir_pkg::*;
#(
  parameter int WIDTH     = IOB_COUNT,
  parameter int IDX_WIDTH = IOB_ADDR_WIDTH
) (
  input  logic [WIDTH-1:0]     vec,
  output logic [IDX_WIDTH-1:0] idx,
  output logic                 found
);

  // Scan downwards so the lowest set bit is the last one to update idx
  always_comb begin
    idx   = {IDX_WIDTH{1'b0}};
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      idx   = vec[i] ? IDX_WIDTH'(i) : idx;
      found = found | vec[i];
    end
  end

endmodule

// File: rtl/iob_indir_ctrl.sv
// IOB indirect-store controller: init sweep, allocation, fill/free forwarding and
// round-robin read arbitration. Optional ownership checking: IOB_INDIR_ALLOC_CHK_EN.
module iob_indir_ctrl
  import iob_indir_pkg::*;
#(
  parameter int ADDR_WIDTH = IOB_ADDR_WIDTH,
  parameter int ADDR_COUNT = IOB_COUNT,
  parameter int DATA_WIDTH = IOB_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_done,
  input  logic                  alloc_req,
  output logic                  alloc_gnt,
  output logic [ADDR_WIDTH-1:0] alloc_addr,
  output logic [ADDR_WIDTH:0]   free_cnt,
  input  logic                  fill_wen,
  input  logic [ADDR_WIDTH-1:0] fill_addr,
  input  logic [DATA_WIDTH-1:0] fill_data,
  input  logic                  rd0_req,
  input  logic [ADDR_WIDTH-1:0] rd0_addr,
  input  logic                  rd1_req,
  input  logic [ADDR_WIDTH-1:0] rd1_addr,
  output logic                  rd0_gnt,
  output logic                  rd1_gnt,
  output logic                  rsp_valid,
  output logic                  rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_ready,
  input  logic                  free_en,
  input  logic [ADDR_WIDTH-1:0] free_addr,
  output logic                  err,
  output logic                  ram_read_clkEn,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  input  logic [DATA_WIDTH-1:0] ram_read_data,
  input  logic                  ram_read_ready,
  output logic [ADDR_WIDTH-1:0] ram_write_addr,
  output logic [DATA_WIDTH-1:0] ram_write_data,
  output logic                  ram_write_wen,
  output logic [ADDR_WIDTH-1:0] ram_writeI_addr,
  output logic                  ram_writeI_ready,
  output logic                  ram_writeI_wen
);

  localparam logic [ADDR_WIDTH:0]   COUNT_INIT = (ADDR_WIDTH + 1)'(ADDR_COUNT);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX   = ADDR_WIDTH'(ADDR_COUNT - 1);
  localparam logic [ADDR_COUNT-1:0] ONE_HOT0   = {{(ADDR_COUNT - 1){1'b0}}, 1'b1};

  iob_state_e            state_r, state_nxt_s;
  logic [ADDR_WIDTH-1:0] sweep_cnt_r;
  logic                  init_done_r;
  logic [ADDR_COUNT-1:0] alloc_map_r, alloc_map_nxt_s, set_mask_s, clr_mask_s;
  logic [ADDR_WIDTH:0]   free_cnt_r, free_cnt_nxt_s;
  iob_req_id_t           prio_r, rsp_id_r;
  logic                  rsp_valid_r, err_r;
  logic                  run_s, ffs_found_s, free_ret_s;
  logic [ADDR_WIDTH-1:0] ffs_idx_s;
  logic                  alloc_gnt_s, fill_ok_s, free_ok_s;
  logic                  rd0_v_s, rd1_v_s, gnt0_s, gnt1_s;
  logic                  fill_legal_s, free_legal_s, err_set_s;

  iob_indir_ffs #(.WIDTH(ADDR_COUNT), .IDX_WIDTH(ADDR_WIDTH)) u_ffs (
    .vec   (~alloc_map_r),
    .idx   (ffs_idx_s),
    .found (ffs_found_s)
  );

  assign run_s = (state_r == RUN);

  // Next state: one pass over every index, then stay in RUN until rst
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      INIT:    state_nxt_s = (sweep_cnt_r == LAST_IDX) ? RUN : INIT;
      RUN:     state_nxt_s = RUN;
      default: state_nxt_s = INIT;
    endcase
  end

  // State register, sweep counter and init_done flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= INIT;
      sweep_cnt_r <= {ADDR_WIDTH{1'b0}};
      init_done_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      sweep_cnt_r <= (state_r == INIT) ? sweep_cnt_r + 1'b1 : sweep_cnt_r;
      init_done_r <= (state_nxt_s == RUN);
    end
  end

`ifdef IOB_INDIR_ALLOC_CHK_EN
  assign fill_legal_s = alloc_map_r[fill_addr];
  assign free_legal_s = alloc_map_r[free_addr];
  // Reads of unowned entries are flagged but still served
  assign err_set_s    = run_s && ((fill_wen && !fill_legal_s) || (free_en && !free_legal_s) ||
                                  (gnt0_s && !alloc_map_r[rd0_addr]) ||
                                  (gnt1_s && !alloc_map_r[rd1_addr]));
`else
  assign fill_legal_s = 1'b1;
  assign free_legal_s = 1'b1;
  assign err_set_s    = 1'b0;
`endif

  assign alloc_gnt_s = run_s && alloc_req && (free_cnt_r != {(ADDR_WIDTH + 1){1'b0}}) && ffs_found_s;
  assign fill_ok_s   = run_s && fill_wen && fill_legal_s;
  assign free_ok_s   = run_s && free_en && free_legal_s;
  assign rd0_v_s     = run_s && rd0_req;
  assign rd1_v_s     = run_s && rd1_req;
  assign gnt0_s      = rd0_v_s && (!rd1_v_s || (prio_r == 1'b0));
  assign gnt1_s      = rd1_v_s && (!rd0_v_s || (prio_r == 1'b1));

  // Free is applied before allocate, so a freed slot only reappears next cycle
  assign set_mask_s      = alloc_gnt_s ? (ONE_HOT0 << ffs_idx_s) : {ADDR_COUNT{1'b0}};
  assign clr_mask_s      = free_ok_s ? (ONE_HOT0 << free_addr) : {ADDR_COUNT{1'b0}};
  assign alloc_map_nxt_s = (alloc_map_r & ~clr_mask_s) | set_mask_s;
  assign free_ret_s      = free_ok_s && alloc_map_r[free_addr];
  assign free_cnt_nxt_s  = free_cnt_r + (ADDR_WIDTH + 1)'(free_ret_s) - (ADDR_WIDTH + 1)'(alloc_gnt_s);

  // Allocation bitmap and free-entry count
  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_map_r <= {ADDR_COUNT{1'b0}};
      free_cnt_r  <= COUNT_INIT;
    end else begin
      alloc_map_r <= alloc_map_nxt_s;
      free_cnt_r  <= free_cnt_nxt_s;
    end
  end

  // Ready-only port: sweep index while in INIT, released index in RUN
  always_comb begin
    if (run_s) begin
      ram_writeI_wen  = free_ok_s;
      ram_writeI_addr = free_addr;
    end else begin
      ram_writeI_wen  = 1'b1;
      ram_writeI_addr = sweep_cnt_r;
    end
  end

  // Arbitration pointer, response tracking and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_r      <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      prio_r      <= (rd0_v_s && rd1_v_s) ? ~prio_r : prio_r;
      rsp_valid_r <= gnt0_s | gnt1_s;
      rsp_id_r    <= (gnt0_s | gnt1_s) ? iob_req_id_t'(gnt1_s) : rsp_id_r;
      err_r       <= err_r | err_set_s;
    end
  end

  assign ram_writeI_ready = 1'b0;
  assign ram_write_wen    = fill_ok_s;
  assign ram_write_addr   = fill_addr;
  assign ram_write_data   = fill_data;
  assign ram_read_clkEn   = gnt0_s | gnt1_s;
  assign ram_read_addr    = gnt1_s ? rd1_addr : rd0_addr;

  assign init_done  = init_done_r;
  assign alloc_gnt  = alloc_gnt_s;
  assign alloc_addr = ffs_idx_s;
  assign free_cnt   = free_cnt_r;
  assign rd0_gnt    = gnt0_s;
  assign rd1_gnt    = gnt1_s;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_id     = rsp_id_r;
  assign rsp_data   = ram_read_data;
  assign rsp_ready  = ram_read_ready;
  assign err        = err_r;

endmodule

// File: tb/tb_iob_indir_ctrl.sv
// Self-checking bench for iob_indir_ctrl: directed scenarios plus randomized traffic
// against an entry-level model of ownership, contents and arbitration.
module tb_iob_indir_ctrl;
  localparam int AW = 6;
  localparam int N  = 64;
  localparam int DW = 65;

  logic clk = 1'b0, rst = 1'b0;
  logic init_done, alloc_req, alloc_gnt, fill_wen, rd0_req, rd1_req, rd0_gnt, rd1_gnt;
  logic rsp_valid, rsp_id, rsp_ready, free_en, err;
  logic [AW-1:0] alloc_addr, fill_addr, rd0_addr, rd1_addr, free_addr;
  logic [AW:0] free_cnt;
  logic [DW-1:0] fill_data, rsp_data, ram_read_data, ram_write_data;
  logic ram_read_clkEn, ram_read_ready, ram_write_wen, ram_writeI_ready, ram_writeI_wen;
  logic [AW-1:0] ram_read_addr, ram_write_addr, ram_writeI_addr;

  iob_indir_ctrl dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_addr(alloc_addr), .free_cnt(free_cnt),
    .fill_wen(fill_wen), .fill_addr(fill_addr), .fill_data(fill_data),
    .rd0_req(rd0_req), .rd0_addr(rd0_addr), .rd1_req(rd1_req), .rd1_addr(rd1_addr),
    .rd0_gnt(rd0_gnt), .rd1_gnt(rd1_gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_ready(rsp_ready), .free_en(free_en), .free_addr(free_addr),
    .err(err), .ram_read_clkEn(ram_read_clkEn), .ram_read_addr(ram_read_addr),
    .ram_read_data(ram_read_data), .ram_read_ready(ram_read_ready),
    .ram_write_addr(ram_write_addr), .ram_write_data(ram_write_data), .ram_write_wen(ram_write_wen),
    .ram_writeI_addr(ram_writeI_addr), .ram_writeI_ready(ram_writeI_ready),
    .ram_writeI_wen(ram_writeI_wen)
  );

  always #5 clk = ~clk;

  // Behavioural store: registered read address, ready-only write beats data write
  logic [DW-1:0] mem [N];
  logic          rdy [N];
  logic [AW-1:0] rd_addr_q = '0;
  always @(posedge clk) begin
    if (ram_read_clkEn) rd_addr_q <= ram_read_addr;
    if (ram_write_wen) begin
      mem[ram_write_addr] <= ram_write_data;
      rdy[ram_write_addr] <= 1'b1;
    end
    if (ram_writeI_wen) rdy[ram_writeI_addr] <= ram_writeI_ready;
  end
  assign ram_read_data  = mem[rd_addr_q];
  assign ram_read_ready = rdy[rd_addr_q];

  // Reference model state
  bit            alloc_m [N];
  logic [DW-1:0] data_m  [N];
  bit            ready_m [N];
  bit            prio_m, err_m;
  int            checks = 0, failures = 0;
  bit            last_agnt, last_g1;
  logic [AW-1:0] last_aaddr;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  function automatic int free_count();
    int c = 0;
    for (int i = 0; i < N; i++) if (!alloc_m[i]) c++;
    return c;
  endfunction

  function automatic int lowest_free();
    for (int i = 0; i < N; i++) if (!alloc_m[i]) return i;
    return -1;
  endfunction

  function automatic bit pick_alloc(output logic [AW-1:0] a);
    int s = $urandom_range(0, N - 1);
    for (int k = 0; k < N; k++) begin
      if (alloc_m[(s + k) % N]) begin
        a = AW'((s + k) % N);
        return 1'b1;
      end
    end
    a = '0;
    return 1'b0;
  endfunction

  task automatic idle();
    alloc_req = 0; fill_wen = 0; fill_addr = '0; fill_data = '0; free_en = 0; free_addr = '0;
    rd0_req = 0; rd0_addr = '0; rd1_req = 0; rd1_addr = '0;
  endtask

  // One RUN cycle: inputs already driven; check combinational outputs, step, check responses
  task automatic run_cycle();
    bit agnt, g0, g1, chk_en, fill_e, free_e;
    int la;
    logic [AW-1:0] raddr;
    chk_en = 1'b0;
`ifdef IOB_INDIR_ALLOC_CHK_EN
    chk_en = 1'b1;
`endif
    #3;
    agnt   = alloc_req && (free_count() != 0);
    la     = lowest_free();
    g0     = rd0_req && (!rd1_req || !prio_m);
    g1     = rd1_req && (!rd0_req || prio_m);
    raddr  = g1 ? rd1_addr : rd0_addr;
    fill_e = fill_wen && (!chk_en || alloc_m[fill_addr]);
    free_e = free_en && (!chk_en || alloc_m[free_addr]);
    last_agnt = alloc_gnt; last_aaddr = alloc_addr; last_g1 = rd1_gnt;
    chk("alloc_gnt", alloc_gnt, agnt);
    if (agnt) chk("alloc_addr", alloc_addr, la);
    chk("free_cnt", free_cnt, free_count());
    chk("rd0_gnt", rd0_gnt, g0);
    chk("rd1_gnt", rd1_gnt, g1);
    chk("ram_read_clkEn", ram_read_clkEn, g0 | g1);
    if (g0 || g1) chk("ram_read_addr", ram_read_addr, raddr);
    chk("ram_write_wen", ram_write_wen, fill_e);
    if (fill_e) begin
      chk("ram_write_addr", ram_write_addr, fill_addr);
      chk("ram_write_data", ram_write_data, fill_data);
    end
    chk("ram_writeI_wen", ram_writeI_wen, free_e);
    if (free_e) chk("ram_writeI_addr", ram_writeI_addr, free_addr);
    chk("ram_writeI_ready", ram_writeI_ready, 0);
    if (chk_en && ((fill_wen && !alloc_m[fill_addr]) || (free_en && !alloc_m[free_addr]) ||
                   (g0 && !alloc_m[rd0_addr]) || (g1 && !alloc_m[rd1_addr]))) err_m = 1'b1;
    if (fill_e) begin data_m[fill_addr] = fill_data; ready_m[fill_addr] = 1'b1; end
    if (free_e) begin ready_m[free_addr] = 1'b0; alloc_m[free_addr] = 1'b0; end
    if (agnt) alloc_m[la] = 1'b1;
    if (rd0_req && rd1_req) prio_m = !prio_m;
    @(posedge clk); #1;
    chk("rsp_valid", rsp_valid, g0 | g1);
    if (g0 || g1) begin
      chk("rsp_id", rsp_id, g1);
      chk("rsp_data", rsp_data, data_m[raddr]);
      chk("rsp_ready", rsp_ready, ready_m[raddr]);
    end
    chk("err", err, err_m);
    chk("init_done", init_done, 1);
  endtask

  // One-cycle rst, then follow the sweep; noisy drives requests that must be ignored
  task automatic do_reset(input bit noisy);
    int sweep = 0;
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < N; i++) alloc_m[i] = 1'b0;
    prio_m = 1'b0; err_m = 1'b0;
    chk("rst_init_done", init_done, 0);
    chk("rst_free_cnt", free_cnt, N);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_err", err, 0);
    if (noisy) begin
      alloc_req = 1; rd0_req = 1; rd1_req = 1; fill_wen = 1; free_en = 1;
    end
    for (int i = 0; i < 3 * N && init_done !== 1'b1; i++) begin
      #3;
      chk("sweep_wen", ram_writeI_wen, 1);
      chk("sweep_addr", ram_writeI_addr, i);
      chk("sweep_ready", ram_writeI_ready, 0);
      chk("init_alloc_gnt", alloc_gnt, 0);
      chk("init_rd_gnt", {rd0_gnt, rd1_gnt, ram_read_clkEn}, 0);
      chk("init_write_wen", ram_write_wen, 0);
      sweep++;
      @(posedge clk); #1;
    end
    idle();
    chk("sweep_len", sweep, N);
    chk("init_done_set", init_done, 1);
    chk("init_free_cnt", free_cnt, N);
    chk("init_rsp_valid", rsp_valid, 0);
    for (int i = 0; i < N; i++) ready_m[i] = 1'b0;
  endtask

  initial begin
    logic [AW-1:0] a;
    bit ok;
    for (int i = 0; i < N; i++) begin
      mem[i]    = DW'(i * 7 + 3);
      data_m[i] = DW'(i * 7 + 3);
    end
    idle();
    do_reset(1'b0);

    // Back-to-back allocation, then reuse of a freed slot
    alloc_req = 1;
    for (int i = 0; i < 3; i++) begin
      run_cycle();
      chk("alloc_seq", last_aaddr, i);
    end
    chk("free_cnt_61", free_cnt, 61);
    alloc_req = 0; free_en = 1; free_addr = 6'd1;
    run_cycle();
    free_en = 0; alloc_req = 1;
    run_cycle();
    chk("realloc_1", {last_agnt, last_aaddr}, {1'b1, 6'd1});

    // Exhaust the pool; free+alloc in one cycle must not grant the freed entry
    for (int i = 0; i < N + 4 && free_count() != 0; i++) run_cycle();
    chk("full_free_cnt", free_cnt, 0);
    run_cycle();
    chk("full_no_gnt", last_agnt, 0);
    free_en = 1; free_addr = 6'd63;
    run_cycle();
    chk("free_alloc_same", last_agnt, 0);
    free_en = 0;
    run_cycle();
    chk("regrant_63", {last_agnt, last_aaddr}, {1'b1, 6'd63});

    // Fill and read back, then free and observe ready cleared
    alloc_req = 0; fill_wen = 1; fill_addr = 6'd5; fill_data = 65'h1_0000_0000_DEAD_BEEF;
    run_cycle();
    fill_wen = 0; rd0_req = 1; rd0_addr = 6'd5;
    run_cycle();
    chk("rd5_data", rsp_data, 65'h1_0000_0000_DEAD_BEEF);
    chk("rd5_ready", {rsp_valid, rsp_id, rsp_ready}, 3'b101);
    rd0_req = 0; free_en = 1; free_addr = 6'd5;
    run_cycle();
    free_en = 0; rd0_req = 1;
    run_cycle();
    chk("rd5_freed_ready", rsp_ready, 0);

    // Read and fill of one index in the same cycle returns the new data
    rd0_req = 0; rd1_req = 1; rd1_addr = 6'd6; fill_wen = 1; fill_addr = 6'd6;
    fill_data = 65'h0_1234_5678_9ABC_DEF0;
    run_cycle();
    chk("rd_fill_same", rsp_data, 65'h0_1234_5678_9ABC_DEF0);
    // Fill and free of one index together: data written, ready cleared
    rd1_req = 0; fill_addr = 6'd7; fill_data = 65'h1_5555_AAAA_0000_FFFF; free_en = 1; free_addr = 6'd7;
    run_cycle();
    fill_wen = 0; free_en = 0; rd1_req = 1; rd1_addr = 6'd7;
    run_cycle();
    chk("fill_free_ready", rsp_ready, 0);
    idle();

    // Reset mid-traffic, then both requesters continuously: grants alternate from 0
    rd0_req = 1; rd1_req = 1;
    run_cycle();
    do_reset(1'b1);
    alloc_req = 1;
    run_cycle();
    run_cycle();
    alloc_req = 0; rd0_req = 1; rd0_addr = 6'd0; rd1_req = 1; rd1_addr = 6'd1;
    for (int i = 0; i < 6; i++) begin
      run_cycle();
      chk("arb_alt", last_g1, i % 2);
    end

    // Randomized legal traffic
    for (int c = 0; c < 400; c++) begin
      idle();
      alloc_req = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 1) == 0) begin
        ok = pick_alloc(a);
        fill_wen = ok; fill_addr = a;
        fill_data = DW'({$urandom(), $urandom(), $urandom()});
      end
      if ($urandom_range(0, 2) == 0) begin
        ok = pick_alloc(a);
        free_en = ok; free_addr = a;
      end
      if ($urandom_range(0, 1) == 0) begin
        ok = pick_alloc(a);
        rd0_req = ok; rd0_addr = a;
      end
      if ($urandom_range(0, 1) == 0) begin
        ok = pick_alloc(a);
        rd1_req = ok; rd1_addr = a;
      end
      run_cycle();
    end
    idle();

`ifdef IOB_INDIR_ALLOC_CHK_EN
    // Fill of an unallocated entry is dropped and latches err until rst
    do_reset(1'b0);
    fill_wen = 1; fill_addr = 6'd9; fill_data = 65'h0_0000_0000_0000_0009;
    run_cycle();
    chk("err_fill9", {err, last_agnt}, 2'b10);
    idle();
    for (int i = 0; i < 3; i++) run_cycle();
    chk("err_sticky", err, 1);
    do_reset(1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iob_indir_ctrl.md
Name: iob_indir_ctrl

Overview:
- Controller for the IOB indirect store, which is a 65-bit data RAM plus a 1-bit ready RAM with registered read address and no reset on contents.
- Runs a post-reset init sweep that clears every ready bit.
- Allocates free entry indices to producers and forwards fill writes.
- Arbitrates the single read port between two consumers, round-robin.
- Returns freed entries to the pool and clears their ready bit.

Parameters:
- ADDR_WIDTH, 6, entry index width.
- ADDR_COUNT, 64, number of entries (must be at most 2**ADDR_WIDTH).
- DATA_WIDTH, 65, entry payload width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- init_done  out  1  high once the init sweep has completed
- alloc_req  in  1  request one free entry
- alloc_gnt  out  1  allocation granted this cycle
- alloc_addr  out  ADDR_WIDTH  granted entry index
- free_cnt  out  ADDR_WIDTH+1  number of free entries
- fill_wen  in  1  write payload into an allocated entry
- fill_addr  in  ADDR_WIDTH  fill target index
- fill_data  in  DATA_WIDTH  fill payload
- rd0_req / rd1_req  in  1  read request, requester 0 / 1
- rd0_addr / rd1_addr  in  ADDR_WIDTH  read index
- rd0_gnt / rd1_gnt  out  1  read granted this cycle
- rsp_valid  out  1  read response valid
- rsp_id  out  1  requester the response belongs to
- rsp_data  out  DATA_WIDTH  entry payload
- rsp_ready  out  1  entry ready bit at read time
- free_en  in  1  release an entry
- free_addr  in  ADDR_WIDTH  index being released
- err  out  1  sticky protocol error
- ram_read_clkEn  out  1  RAM read-address enable
- ram_read_addr  out  ADDR_WIDTH  RAM read address
- ram_read_data  in  DATA_WIDTH  RAM read data
- ram_read_ready  in  1  RAM ready bit
- ram_write_addr  out  ADDR_WIDTH  RAM data write address
- ram_write_data  out  DATA_WIDTH  RAM data write payload
- ram_write_wen  out  1  data write enable; the RAM also sets the ready bit
- ram_writeI_addr  out  ADDR_WIDTH  ready-only write address
- ram_writeI_ready  out  1  ready-only write value; always 0
- ram_writeI_wen  out  1  ready-only write enable

Behaviour:
- FSM states: INIT and RUN. rst forces INIT from any state, mid-operation included.
- Reset values: sweep counter = 0; alloc bitmap all free; free_cnt = ADDR_COUNT; prio = 0; err = 0; rsp_valid = 0; all grants and wens = 0.
- INIT, per cycle: ram_writeI_wen = 1, ram_writeI_addr = counter, ready value 0; counter increments.
  - After index ADDR_COUNT-1 the FSM moves to RUN. Sweep takes ADDR_COUNT cycles.
  - init_done is registered high on entering RUN.
  - All requests (alloc, fill, read, free) are ignored in INIT.
- Allocation, RUN:
  - alloc_gnt = alloc_req && free_cnt != 0, combinational.
  - alloc_addr = lowest-index free entry.
  - The entry is marked allocated at the edge.
  - free_cnt = 0 means no grant; alloc_addr is don't-care.
- Fill: ram_write_* is driven combinationally from fill_*, gated by RUN. The RAM sets ready = 1.
- Free, RUN:
  - Drives ram_writeI_wen = 1 at free_addr, clearing ready.
  - Bitmap bit is cleared at the edge.
  - A freed entry is not allocatable until the next cycle.
  - Alloc and free in the same cycle: free_cnt is unchanged.
- Read arbitration:
  - Single requester: that requester is granted.
  - Both requesting: requester == prio is granted, then prio flips.
  - ram_read_clkEn = any grant; ram_read_addr = the granted address.
  - Latency is 1: rsp_valid and rsp_id are registered the cycle after the grant.
  - rsp_data and rsp_ready pass combinationally from the RAM.
  - rsp_valid deasserts the following cycle unless a new grant occurred.
- Same-cycle interactions:
  - A read and a fill/free to the same index in one cycle: the response reflects the new contents (write-first via the registered read address).
  - Fill and free to the same index in one cycle: free wins for ready (writeI clears it); the data is still written.

Optional Feature:
- Macro IOB_INDIR_ALLOC_CHK_EN.
- With the macro: fill, free or read of an entry not marked allocated sets err (sticky until rst).
  - An offending fill or free is suppressed.
  - An offending read is still granted.
- Without the macro: no checks; err is tied 0; all accesses pass through.

Decomposition:
- Shared package holds:
  - FSM state typedef (INIT, RUN).
  - Constants IOB_ADDR_WIDTH, IOB_COUNT, IOB_DATA_WIDTH.
  - Requester-id typedef.
- One sub-module: iob_indir_ffs, a lowest-set-bit finder over the free bitmap returning index and found flag.

Test Plan:
- rst for 1 cycle: ram_writeI_wen is high for exactly 64 cycles, addresses 0..63, ready value 0; then init_done = 1 and free_cnt = 64.
- 3 back-to-back alloc_req: alloc_addr = 0, 1, 2; free_cnt = 61. Then free_en on 1 followed by alloc: grants 1.
- Allocate all 64 entries, then alloc_req: alloc_gnt = 0, free_cnt = 0. Free 63 and alloc in the same cycle: no grant; next cycle grants 63.
- Fill addr 5 with data 0x1_0000_0000_DEAD_BEEF, then rd0 at addr 5: one cycle later rsp_valid = 1, rsp_id = 0, rsp_data matches, rsp_ready = 1. Free 5, then read again: rsp_ready = 0.
- rd0 and rd1 both requesting continuously: grants alternate 0,1,0,1 starting from 0 after reset; each response is 1 cycle after its grant.
- With IOB_INDIR_ALLOC_CHK_EN, fill of unallocated addr 9: err = 1, ram_write_wen = 0. err stays set until rst.
